// File: rtl/common_pkg.sv
// Shared datapath constants for the Abejaruco core.
package common_pkg;

  localparam int unsigned WORD_WIDTH = 32;

endpackage

// File: rtl/flip_flop_stage.sv
// Single N-bit register with synchronous reset.
// Clock enable present with FLIP_FLOP_CLOCK_ENABLE_EN.
module flip_flop_stage
  import common_pkg::*;
#(
  parameter int unsigned  N           = WORD_WIDTH,
  parameter logic [N-1:0] RESET_VALUE = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
`ifdef FLIP_FLOP_CLOCK_ENABLE_EN
  input  logic         en,
`endif
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = d;
`ifdef FLIP_FLOP_CLOCK_ENABLE_EN
    if (!en) begin
      q_d = q_q;
    end
`endif
  end

  // Reset wins over both data and enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/flip_flop.sv
// N-bit register chain of STAGES cycles latency.
// Optional clock enable: define FLIP_FLOP_CLOCK_ENABLE_EN.
module flip_flop
  import common_pkg::*;
#(
  parameter int unsigned  N           = WORD_WIDTH,
  parameter logic [N-1:0] RESET_VALUE = {N{1'b0}},
  parameter int unsigned  STAGES      = 1
) (
  input  logic         clk,
  input  logic         reset,
`ifdef FLIP_FLOP_CLOCK_ENABLE_EN
  input  logic         en,
`endif
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  if (N < 1) begin : g_bad_n
    $fatal(1, "flip_flop: N must be >= 1");
  end

  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "flip_flop: STAGES must be >= 1");
  end

  // chain[0] is the input; chain[k+1] is stage k's output.
  logic [STAGES:0][N-1:0] chain;

  assign chain[0] = d;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    flip_flop_stage #(
      .N           (N),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
`ifdef FLIP_FLOP_CLOCK_ENABLE_EN
      .en    (en),
`endif
      .d     (chain[k]),
      .q     (chain[k+1])
    );
  end

  assign q = chain[STAGES];

endmodule

// File: tb/tb_flip_flop.sv
// Self-checking bench for flip_flop in three configurations.
// Reference: history of effective edges (loads and resets).
module tb_flip_flop;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] d = '0;
  logic [31:0] q1;
  logic [31:0] q3;
  logic [7:0]  q8;
`ifdef FLIP_FLOP_CLOCK_ENABLE_EN
  logic        en = 1'b1;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] hd[$];
  bit          hr[$];

  always #5 clk = ~clk;

  flip_flop #(.N(32), .STAGES(1)) u1 (
    .clk   (clk),
    .reset (reset),
`ifdef FLIP_FLOP_CLOCK_ENABLE_EN
    .en    (en),
`endif
    .d     (d),
    .q     (q1)
  );

  flip_flop #(.N(32), .STAGES(3)) u3 (
    .clk   (clk),
    .reset (reset),
`ifdef FLIP_FLOP_CLOCK_ENABLE_EN
    .en    (en),
`endif
    .d     (d),
    .q     (q3)
  );

  flip_flop #(.N(8), .RESET_VALUE(8'h5A), .STAGES(4)) u8 (
    .clk   (clk),
    .reset (reset),
`ifdef FLIP_FLOP_CLOCK_ENABLE_EN
    .en    (en),
`endif
    .d     (d[7:0]),
    .q     (q8)
  );

  function automatic bit en_eff();
`ifdef FLIP_FLOP_CLOCK_ENABLE_EN
    return en;
`else
    return 1'b1;
`endif
  endfunction

  // Output of an s-deep chain: reset value if any of the last s
  // effective edges was a reset, else d from s effective edges ago.
  function automatic logic [31:0] model(int s, logic [31:0] rv,
                                        logic [31:0] mask);
    int n = hd.size();
    int lo = (n > s) ? n - s : 0;
    for (int i = lo; i < n; i++) begin
      if (hr[i]) return rv;
    end
    if (n < s) return 'x;
    return hd[n-s] & mask;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, "/s1"}, q1, model(1, 32'h0, 32'hFFFF_FFFF));
    check({tag, "/s3"}, q3, model(3, 32'h0, 32'hFFFF_FFFF));
    check({tag, "/s4"}, {24'h0, q8}, model(4, 32'h5A, 32'hFF));
  endtask

  task automatic step();
    bit r = reset;
    bit e = en_eff();
    logic [31:0] v = d;
    @(posedge clk);
    if (r || e) begin
      hd.push_back(v);
      hr.push_back(r);
    end
    #1;
  endtask

  logic [31:0] held;

  initial begin
    @(negedge clk);
    reset = 1'b1;
    d = 32'h1234_5678;
    step();
    check("rst1", q1, 32'h0);
    check("rst8", {24'h0, q8}, 32'h5A);
    check_all("reset");

    reset = 1'b0;
    d = 32'hFFFF_FFFF;
    step();
    check("ones", q1, 32'hFFFF_FFFF);
    check_all("ones");

    reset = 1'b1;
    d = $urandom;
    step();
    check("rst_any_d", q1, 32'h0);
    check_all("rst_any_d");

    reset = 1'b0;
    d = 32'h0;
    step();
    check("zero", q1, 32'h0);
    d = 32'hA5A5_A5A5;
    step();
    check("a5", q1, 32'hA5A5_A5A5);
    check_all("a5");

    held = q1;
    d = 32'h0F0F_0F0F;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("glitch", q1, held);
    check_all("glitch");

    reset = 1'b1;
    step();
    reset = 1'b0;
    d = 32'h1;
    step();
    check("seq3_e1", q3, 32'h0);
    d = 32'h2;
    step();
    check("seq3_e2", q3, 32'h0);
    d = 32'h3;
    step();
    check("seq3_e3", q3, 32'h1);
    d = 32'h4;
    step();
    check("seq3_e4", q3, 32'h2);
    check("seq4_e4", {24'h0, q8}, 32'h1);
    d = 32'h5;
    step();
    check("seq3_e5", q3, 32'h3);
    reset = 1'b1;
    step();
    check("midrst3", q3, 32'h0);
    check("midrst4", {24'h0, q8}, 32'h5A);
    reset = 1'b0;
    d = 32'h6;
    step();
    check("refill3", q3, 32'h0);
    check_all("refill");

`ifdef FLIP_FLOP_CLOCK_ENABLE_EN
    d = 32'hDEAD_BEEF;
    step();
    held = q1;
    en = 1'b0;
    d = 32'h1111_2222;
    step();
    check("en0_hold", q1, held);
    check_all("en0_hold");
    reset = 1'b1;
    step();
    check("en0_rst", q1, 32'h0);
    check("en0_rst8", {24'h0, q8}, 32'h5A);
    reset = 1'b0;
    en = 1'b1;
    d = 32'h3333_4444;
    step();
    check("en1_load", q1, 32'h3333_4444);
    check_all("en1_load");
`endif

    for (int i = 0; i < 60; i++) begin
      reset = ($urandom_range(7) == 0);
      d = $urandom;
`ifdef FLIP_FLOP_CLOCK_ENABLE_EN
      en = $urandom_range(1);
`endif
      step();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
